// File: rtl/adder_seq_if.sv
// Operand/result handshake bundle for adder_seq.
// The master side issues operands and consumes results; the slave side is the adder.
interface adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_cout;
  logic             out_ovf;
  logic [2:0]       out_nzp;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out, out_cout, out_ovf, out_nzp
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out, out_cout, out_ovf, out_nzp
  );
endinterface

// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry,
// returning sum, carry-out, signed overflow and LC-3 NZP codes.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_seq_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, out_q, out_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out, c_msb, last;
  logic [WIDTH-1:0] full_sum;

  // Chunk selection by shifting keeps the index width independent of WIDTH.
  always_comb begin
    base             = 32'(cnt_q) * 32'(CHUNK);
    a_ch             = CHUNK'(a_q >> base);
    b_ch             = CHUNK'(b_q >> base);
    {c_out, s_ch}    = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(c_q);
    // Carry into the MSB recovered from the MSB's sum bit and its operands.
    c_msb            = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    last             = (cnt_q == CW'(NCH - 1));
    full_sum         = (sum_q & ~(MASK << base)) | (WIDTH'(s_ch) << base);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    nzp_d   = nzp_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          c_d     = bus.in_sub | bus.in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = full_sum;
        c_d   = c_out;
        if (last) begin
          state_d = DONE;
          out_d   = full_sum;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          nzp_d   = {full_sum[WIDTH-1], full_sum == '0,
                     !full_sum[WIDTH-1] && (full_sum != '0)};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      nzp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      nzp_q   <= nzp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_nzp   = nzp_q;
endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: directed vectors and corner sequences on a 16/4 instance,
// plus randomized sweeps on 16/1, 16/4, 16/16 and 32/8 against an arithmetic model.
module tb_adder_seq;
  logic clk = 1'b0;
  logic rst_dir_n = 1'b0;
  logic rst_sw_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] done = '0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Directed instance
  adder_seq_if #(.WIDTH(16)) dif ();
  adder_seq #(.WIDTH(16), .CHUNK(4)) u_dir (.clk(clk), .rst_n(rst_dir_n), .bus(dif));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] out;
    logic        cout;
    logic        ovf;
    logic [2:0]  nzp;
  } vec_t;

  task automatic dir_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, output logic [20:0] res, output int unsigned lat);
    int unsigned n;
    dif.in_a = a; dif.in_b = b; dif.in_sub = sub; dif.in_cin = cin; dif.in_valid = 1'b1;
    n = 0;
    while (!dif.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    dif.in_a = 16'hDEAD; dif.in_b = 16'hBEEF; dif.in_sub = ~sub;
    lat = 0;
    while (!dif.out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    res = {dif.out, dif.out_cout, dif.out_ovf, dif.out_nzp};
    dif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    logic [20:0] res, snap;
    int unsigned lat;
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 3'b001};
    vecs[1] = '{16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0, 3'b001};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 3'b100};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 3'b010};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 3'b010};
    vecs[5] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 3'b100};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 3'b001};

    dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0; dif.in_sub = 1'b0;
    dif.in_cin = 1'b0; dif.out_ready = 1'b0;
    #2;
    chk("reset_state", 64'({dif.in_ready, dif.out_valid, dif.out, dif.out_cout,
                            dif.out_ovf, dif.out_nzp}), 64'({1'b1, 1'b0, 21'h0}));
    #20;
    @(negedge clk);
    rst_dir_n = 1'b1;
    rst_sw_n  = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      dir_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, res, lat);
      chk($sformatf("vec%0d_result", i), 64'(res),
          64'({vecs[i].out, vecs[i].cout, vecs[i].ovf, vecs[i].nzp}));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // Back-pressure with in_valid held and operands changed during RUN
    dif.in_a = 16'h1111; dif.in_b = 16'h2222; dif.in_sub = 1'b0; dif.in_cin = 1'b0;
    dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_a = 16'hFFFF; dif.in_b = 16'hFFFF;
    lat = 0;
    while (!dif.out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    chk("bp_latency", 64'(lat), 64'd4);
    snap = {dif.out, dif.out_cout, dif.out_ovf, dif.out_nzp};
    chk("bp_result", 64'(snap), 64'({16'h3333, 1'b0, 1'b0, 3'b001}));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          64'({dif.out_valid, dif.in_ready, dif.out, dif.out_cout, dif.out_ovf, dif.out_nzp}),
          64'({1'b1, 1'b0, snap}));
    end
    dif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.out_ready = 1'b0;
    chk("bp_release", 64'({dif.in_ready, dif.out_valid, dif.out}), 64'({1'b1, 1'b0, 16'h3333}));
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_accept", 64'(dif.in_ready), 64'd0);
    dif.in_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    chk("bp2_latency", 64'(lat), 64'd4);
    chk("bp2_result", 64'({dif.out, dif.out_cout, dif.out_ovf, dif.out_nzp}),
        64'({16'hFFFE, 1'b1, 1'b0, 3'b100}));
    dif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.out_ready = 1'b0;

    // Asynchronous reset two cycles into RUN
    dif.in_a = 16'h0F0F; dif.in_b = 16'h0101; dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_dir_n = 1'b0;
    #1;
    chk("midrun_reset", 64'({dif.in_ready, dif.out_valid, dif.out, dif.out_cout,
                             dif.out_ovf, dif.out_nzp}), 64'({1'b1, 1'b0, 21'h0}));
    @(negedge clk);
    rst_dir_n = 1'b1;
    @(negedge clk);
    dir_op(16'h00FF, 16'h0001, 1'b0, 1'b0, res, lat);
    chk("post_reset_result", 64'(res), 64'({16'h0100, 1'b0, 1'b0, 3'b001}));
    chk("post_reset_latency", 64'(lat), 64'd4);

    for (int t = 0; t < 80000 && done != 4'hF; t++) @(negedge clk);
    chk("sweep_done", 64'(done), 64'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Randomized parameter sweep
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 3) ? 32 : 16;
    localparam int C = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 8;
    localparam int N = W / C;

    adder_seq_if #(.WIDTH(W)) bus ();
    adder_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_sw_n), .bus(bus));

    initial begin
      logic [W-1:0] a, b, res;
      logic         sub, cin, cout, ovf;
      logic [2:0]   nzp;
      logic [W:0]   full;
      longint       sa, sb, sr, smax, smin;
      int unsigned  lat;
      logic [63:0]  snap;
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
      bus.in_sub = 1'b0; bus.in_cin = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      while (!rst_sw_n) @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        a = W'($urandom); b = W'($urandom);
        if ($urandom_range(0, 7) == 0) a = {1'b0, {(W-1){1'b1}}};
        if ($urandom_range(0, 7) == 0) b = '1;
        sub = 1'($urandom); cin = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk($sformatf("sw%0d_ready", g), 64'(bus.in_ready), 64'd1);
        bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_cin = cin; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = W'($urandom); bus.in_b = W'($urandom); bus.in_sub = ~sub;
        lat = 0;
        while (!bus.out_valid && lat < N + 4) begin @(posedge clk); lat++; @(negedge clk); end
        chk($sformatf("sw%0d_latency", g), 64'(lat), 64'(N));

        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
          res  = a - b;
          cout = (a >= b);
          sr   = sa - sb;
        end else begin
          full = W'(a) + W'(b) + (W+1)'(cin);
          full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
          res  = full[W-1:0];
          cout = full[W];
          sr   = sa + sb + longint'(cin);
        end
        ovf = (sr > smax) || (sr < smin);
        nzp = {$signed(res) < 0, res == '0, $signed(res) > 0};
        chk($sformatf("sw%0d_op%0d", g, i),
            64'({bus.out, bus.out_cout, bus.out_ovf, bus.out_nzp}),
            64'({res, cout, ovf, nzp}));

        snap = 64'({bus.out, bus.out_cout, bus.out_ovf, bus.out_nzp});
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("sw%0d_stall", g),
              {bus.out_valid, bus.in_ready, 62'({bus.out, bus.out_cout, bus.out_ovf, bus.out_nzp})},
              {1'b1, 1'b0, snap[61:0]});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("sw%0d_xfer", g), 64'({bus.in_ready, bus.out_valid}), 64'b10);
      end
      done[g] = 1'b1;
    end
  end
endmodule

// File: doc/adder_seq.md
# adder_seq

Parametrised multi-cycle adder/subtractor for the LC-3 datapath. It processes CHUNK bits per clock, carrying between chunks through a registered carry, so wide operands can be traded for fewer LUTs and a shorter critical path. It accepts operands over a valid/ready handshake and returns the sum with carry-out, signed overflow and LC-3 NZP condition codes over a second valid/ready handshake. It is the sequential, width-generic successor to the fixed 16-bit combinational ripple adder.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- CHUNK, 4, bits added per cycle; must divide WIDTH and satisfy 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1: A − B; 0: A + B + in_cin.
- in_cin  in  1  carry-in for add; ignored when in_sub = 1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  sum/difference.
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_nzp  out  3  {n, z, p} of out; exactly one bit set once a result exists.

## Operation
- NCH = WIDTH/CHUNK chunks. The chunk counter is clog2(NCH) bits wide, minimum 1.
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid, latch a_r = in_a and b_r = in_sub ? ~in_b : in_b. Set the carry register c_r = in_sub ? 1 : in_cin, clear the counter, and go to RUN.
- RUN, each cycle, with chunk k = counter:
  - {c_r, sum_r[k*CHUNK +: CHUNK]} ← a_r chunk + b_r chunk + c_r.
  - On the last chunk (k = NCH−1), also capture the carry into the MSB as c_msb.
  - If k = NCH−1, go to DONE and load the output registers. Otherwise increment k.
- Output registers, loaded at the RUN→DONE edge:
  - out = full sum.
  - out_cout = final carry.
  - out_ovf = c_msb XOR final carry.
  - out_nzp: n = out[WIDTH−1]; z = (out == 0); p = otherwise.
- DONE: out_valid = 1. On out_ready, go to IDLE. out_valid then drops; out, out_cout, out_ovf and out_nzp hold until the next result loads.
- Inputs other than in_valid are sampled only on the accepting edge. Changes while in RUN or DONE have no effect.
- in_valid is ignored outside IDLE; there is no queuing.
- An asynchronous reset in any state aborts the operation and discards partial results.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0.
  - out = 0.
  - out_cout = 0.
  - out_ovf = 0.
  - out_nzp = 3'b000.
  - Internal registers = 0.
- Latency:
  - Operands are accepted at edge T (in_valid && in_ready).
  - out_valid rises after edge T+NCH and carries a valid result in the same cycle.
  - WIDTH=16: CHUNK=4 gives 4 cycles, CHUNK=16 gives 1 cycle, CHUNK=1 gives 16 cycles.
- Output handshake: the result transfers on the edge where out_valid && out_ready. in_ready rises the cycle after that edge.
- Minimum issue interval is NCH+2 cycles with out_ready held high.
- Back-pressure: while out_valid = 1 and out_ready = 0, all outputs stay stable and in_ready = 0.
- in_ready and out_valid are decoded from state registers only. There is no combinational input→output path.

## Test plan
- Add with cross-chunk carry (WIDTH=16, CHUNK=4): A=0x00FF, B=0x0001, cin=0 -> out=0x0100, cout=0, ovf=0, nzp=001. out_valid is seen exactly 4 cycles after accept. Also A=0x1234, B=0x0FF0 -> 0x2224, nzp=001.
- Overflow and wrap:
  - 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1, nzp=100.
  - 0xFFFF+0x0000 with cin=1 -> 0x0000, cout=1, ovf=0, nzp=010.
- Subtract:
  - 0x0005−0x0005 with in_cin=1 (cin must be ignored) -> 0x0000, cout=1, ovf=0, nzp=010.
  - 0x0003−0x0005 -> 0xFFFE, cout=0, nzp=100.
  - 0x8000−0x0001 -> 0x7FFF, ovf=1, nzp=001.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 continuously.
  - out_valid, out and flags stay stable and in_ready stays 0.
  - The first new accept occurs the cycle after out_ready=1.
  - Operands changed during RUN do not alter the result.
- Reset mid-operation: drop rst_n asynchronously 2 cycles into RUN.
  - All outputs are at reset values immediately and in_ready=1.
  - The next operation after release gives a correct result with full latency.
- Parameter sweep: instances with CHUNK ∈ {1, 4, 16} at WIDTH=16, plus WIDTH=32/CHUNK=8.
  - 1000 random operations each (random in_sub, in_cin, out_ready stalls) are checked against a behavioural model.
  - Latency is exactly NCH in every case.
